// File: rtl/fft4_in_loader.sv
// Input stage of the 4-point FFT: packs complex samples into 4-lane frames
// through a two-bank ping-pong buffer and provides the constant twiddle buses.
module fft4_in_loader #(
  parameter bit LAST_CHECK = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [31:0]  s_re,
  input  logic [31:0]  s_im,
  input  logic         s_last,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] A_r,
  output logic [127:0] A_i,
  output logic [63:0]  W_r,
  output logic [63:0]  W_i,
  output logic         frame_err
);

  logic [1:0][3:0][31:0] re_q, im_q;
  logic                  wbank_q, wbank_d;
  logic                  rbank_q, rbank_d;
  logic [1:0]            widx_q, widx_d;
  logic [1:0]            full_q, full_d;
  logic                  err_q, err_d;
  logic                  accept, consume;

  assign s_ready   = !full_q[wbank_q];
  assign m_valid   = full_q[rbank_q];
  assign A_r       = re_q[rbank_q];
  assign A_i       = im_q[rbank_q];
  assign frame_err = err_q;
  assign W_r       = {32'h0000_0000, 32'h3F80_0000};
  assign W_i       = {32'hBF80_0000, 32'h0000_0000};

  assign accept  = s_valid && s_ready;
  assign consume = m_valid && m_ready;

  // Fill bank and read bank never coincide while both are busy, so a commit
  // and a consume in the same cycle touch different full bits.
  always_comb begin
    wbank_d = wbank_q;
    rbank_d = rbank_q;
    widx_d  = widx_q;
    full_d  = full_q;
    err_d   = 1'b0;
    if (accept) begin
      if (LAST_CHECK && s_last && (widx_q != 2'd3)) begin
        widx_d = '0;
        err_d  = 1'b1;
      end else begin
        widx_d = widx_q + 2'd1;
        if (widx_q == 2'd3) begin
          full_d[wbank_q] = 1'b1;
          wbank_d         = ~wbank_q;
          err_d           = LAST_CHECK && !s_last;
        end
      end
    end
    if (consume) begin
      full_d[rbank_q] = 1'b0;
      rbank_d         = ~rbank_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      re_q    <= '0;
      im_q    <= '0;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      widx_q  <= '0;
      full_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        re_q[wbank_q][widx_q] <= s_re;
        im_q[wbank_q][widx_q] <= s_im;
      end
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      widx_q  <= widx_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_fft4_in_loader.sv
// Self-checking bench for fft4_in_loader: reference model with a frame
// scoreboard, a table of frame records, and hand-written corner sequences.
module tb_fft4_in_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid, s_ready, s_last;
  logic [31:0]  s_re, s_im;
  logic         m_valid, m_ready;
  logic [127:0] A_r, A_i;
  logic [63:0]  W_r, W_i;
  logic         frame_err;

  fft4_in_loader #(.LAST_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .A_r(A_r), .A_i(A_i),
    .W_r(W_r), .W_i(W_i), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk128(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model and scoreboard, evaluated at the falling edge
  typedef struct {
    logic [127:0] ar;
    logic [127:0] ai;
  } frame_t;

  frame_t           exp_q[$];
  int               held = 0;
  int               cnt = 0;
  int               err_pulses = 0;
  int               frames_out = 0;
  logic             err_exp = 1'b0;
  logic [3:0][31:0] pre, pim;

  always @(negedge clk) begin
    if (rst) begin
      held    = 0;
      cnt     = 0;
      err_exp = 1'b0;
      exp_q.delete();
    end else begin
      logic   rdy_m, vld_m;
      frame_t f;
      rdy_m = (held < 2);
      vld_m = (held > 0);
      chk1("frame_err", frame_err, err_exp);
      if (frame_err) err_pulses++;
      chk1("m_valid", m_valid, vld_m);
      chk1("s_ready", s_ready, rdy_m);
      if (vld_m && exp_q.size() > 0) begin
        chk128("A_r", A_r, exp_q[0].ar);
        chk128("A_i", A_i, exp_q[0].ai);
      end
      err_exp = 1'b0;
      if (vld_m && m_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        held--;
        frames_out++;
      end
      if (s_valid && rdy_m) begin
        if (s_last && cnt != 3) begin
          cnt     = 0;
          err_exp = 1'b1;
        end else begin
          pre[cnt] = s_re;
          pim[cnt] = s_im;
          if (cnt == 3) begin
            f.ar = pre;
            f.ai = pim;
            exp_q.push_back(f);
            held++;
            cnt     = 0;
            err_exp = !s_last;
          end else begin
            cnt++;
          end
        end
      end
    end
  end

  function automatic logic [31:0] sre(input int unsigned k);
    return 32'h4100_0000 + k;
  endfunction

  function automatic logic [31:0] sim(input int unsigned k);
    return 32'hC000_0000 + k;
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic send(input logic [31:0] re, input logic [31:0] im, input logic last);
    int unsigned n = 0;
    s_valid = 1'b1;
    s_re    = re;
    s_im    = im;
    s_last  = last;
    while (!s_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk1("send_ready", s_ready, 1'b1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    int unsigned      nsamp;
    int unsigned      last_pos;
    logic [3:0][31:0] re;
    logic [3:0][31:0] im;
    int               exp_err;
    int               exp_frames;
  } row_t;

  row_t rows[5];

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout: got no finish expected finish at %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    logic [3:0][31:0] ef, eg;
    int acc, stalls, e0, f0;

    rows[0] = '{2, 1, {32'h0, 32'h0, 32'h4100_00AA, 32'h4100_00A9}, '0, 1, 0};
    rows[1] = '{4, 3, {32'h7F80_0000, 32'h7FC0_0001, 32'hFF80_0000, 32'h0000_0001},
                {32'h8000_0001, 32'h007F_FFFF, 32'hFFFF_FFFF, 32'h8000_0000}, 0, 1};
    rows[2] = '{4, 4, {32'h3F00_0004, 32'h3F00_0003, 32'h3F00_0002, 32'h3F00_0001},
                {32'hBF00_0004, 32'hBF00_0003, 32'hBF00_0002, 32'hBF00_0001}, 1, 1};
    rows[3] = '{3, 2, {32'h0, 32'h1234_5678, 32'h1111_1111, 32'h2222_2222}, '1, 1, 0};
    rows[4] = '{4, 3, {32'hDEAD_BEEF, 32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
                {32'h0000_0002, 32'h7F7F_FFFF, 32'h0080_0000, 32'hCAFE_F00D}, 0, 1};

    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_re = '0; s_im = '0; m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk1("rst_m_valid", m_valid, 1'b0);
    chk1("rst_s_ready", s_ready, 1'b1);
    chk1("rst_frame_err", frame_err, 1'b0);
    chk128("rst_A_r", A_r, '0);
    chk128("rst_A_i", A_i, '0);
    chk128("W_r", {64'h0, W_r}, {64'h0, 32'h0000_0000, 32'h3F80_0000});
    chk128("W_i", {64'h0, W_i}, {64'h0, 32'hBF80_0000, 32'h0000_0000});

    // Basic frame 1.0..4.0
    m_ready = 1'b1;
    send(32'h3F80_0000, '0, 1'b0);
    send(32'h4000_0000, '0, 1'b0);
    send(32'h4040_0000, '0, 1'b0);
    send(32'h4080_0000, '0, 1'b1);
    chk1("t1_m_valid", m_valid, 1'b1);
    chk128("t1_A_r", A_r, {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000});
    chk128("t1_A_i", A_i, '0);
    idle(2);

    // Backpressure: 12 offered, 8 accepted
    m_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      s_valid = 1'b1;
      s_re    = sre(acc);
      s_im    = sim(acc);
      s_last  = (acc % 4 == 3);
      if (s_ready) acc++;
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_last = 1'b0;
    chk_int("bp_accepted", acc, 8);
    chk1("bp_s_ready_low", s_ready, 1'b0);
    for (int l = 0; l < 4; l++) begin
      ef[l] = sre(l);
      eg[l] = sre(l + 4);
    end
    chk128("bp_hold_A_r", A_r, ef);
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    chk128("bp_frame1_A_r", A_r, eg);
    chk1("bp_s_ready_back", s_ready, 1'b1);
    m_ready = 1'b1;
    idle(3);

    // Sustained stream with m_ready held
    stalls = 0;
    e0 = err_pulses;
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1;
      s_re    = sre(100 + i);
      s_im    = sim(100 + i);
      s_last  = (i % 4 == 3);
      if (!s_ready) stalls++;
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_last = 1'b0;
    idle(3);
    chk_int("stream_stalls", stalls, 0);
    chk_int("stream_errs", err_pulses - e0, 0);

    // Table-driven frames, including s_last mismatches
    for (int r = 0; r < 5; r++) begin
      e0 = err_pulses;
      f0 = frames_out;
      for (int unsigned j = 0; j < rows[r].nsamp; j++)
        send(rows[r].re[j], rows[r].im[j], j == rows[r].last_pos);
      idle(3);
      chk_int($sformatf("row%0d_err", r), err_pulses - e0, rows[r].exp_err);
      chk_int($sformatf("row%0d_frames", r), frames_out - f0, rows[r].exp_frames);
    end

    // Reset while one frame held and two samples in the other bank
    m_ready = 1'b0;
    for (int unsigned j = 0; j < 4; j++) send(sre(200 + j), sim(200 + j), j == 3);
    send(sre(210), sim(210), 1'b0);
    send(sre(211), sim(211), 1'b0);
    chk1("pre_rst_m_valid", m_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1("async_rst_m_valid", m_valid, 1'b0);
    chk1("async_rst_s_ready", s_ready, 1'b1);
    chk128("async_rst_A_r", A_r, '0);
    chk128("async_rst_A_i", A_i, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_ready = 1'b1;
    f0 = frames_out;
    for (int unsigned j = 0; j < 4; j++) send(sre(300 + j), sim(300 + j), j == 3);
    idle(3);
    chk_int("post_rst_frames", frames_out - f0, 1);
    chk_int("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
